// File: rtl/ssg_scan_if.sv
// Load handshake and display-pin bundle for the seven-segment scan controller.
interface ssg_scan_if #(
  parameter int DIGITS = 4
);
  logic                  load_valid;
  logic                  load_ready;
  logic [4*DIGITS-1:0]   load_data;
  logic [DIGITS-1:0]     dp_in;
  logic                  lz_en;
  logic [6:0]            ssg;
  logic                  dp;
  logic [DIGITS-1:0]     an;
  logic                  frame_tick;

  modport master (
    output load_valid, load_data, dp_in, lz_en,
    input  load_ready, ssg, dp, an, frame_tick
  );

  modport slave (
    input  load_valid, load_data, dp_in, lz_en,
    output load_ready, ssg, dp, an, frame_tick
  );
endinterface

// File: rtl/ssg_scan_ctrl.sv
// Time-multiplexed common-anode seven-segment scanner with a frame-synchronous
// one-entry load buffer, per-slot blanking dead-time and leading-zero suppression.
module ssg_scan_ctrl #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 3000,
  parameter int BLANK    = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  ssg_scan_if.slave  bus
);

  localparam int CW = $clog2(PRESCALE);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] C_LAST  = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] C_BLANK = CW'(BLANK);
  localparam logic [IW-1:0] I_LAST  = IW'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_DRIVE = 2'd2
  } state_t;

  localparam state_t S_SLOT0 = (BLANK == 0) ? S_DRIVE : S_BLANK;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       w_cnt_nxt;
  logic [IW-1:0]       r_idx;
  logic [IW-1:0]       w_idx_nxt;

  logic [4*DIGITS-1:0] r_disp;
  logic [DIGITS-1:0]   r_dps;
  logic [4*DIGITS-1:0] r_pend;
  logic [DIGITS-1:0]   r_pend_dp;
  logic                r_pend_full;
  logic [4*DIGITS-1:0] w_disp_nxt;
  logic [DIGITS-1:0]   w_dps_nxt;
  logic                w_commit;
  logic                w_xfer;

  logic                w_zero_run;
  logic                w_hit;
  logic [3:0]          w_nib;
  logic                w_sel_supp;
  logic                w_sel_dp;
  logic [6:0]          w_seg;

  logic [6:0]          r_ssg;
  logic                r_dp;
  logic [DIGITS-1:0]   r_an;
  logic                r_ft;

  function automatic logic [6:0] seg_font(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b1100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0001100;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  // Scan position register: phase, slot counter and digit index.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= {CW{1'b0}};
      r_idx   <= {IW{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next scan position; IDLE only exists between reset and the first running cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_SLOT0;
        w_cnt_nxt   = {CW{1'b0}};
        w_idx_nxt   = {IW{1'b0}};
      end
      S_BLANK, S_DRIVE: begin
        if (r_cnt == C_LAST) begin
          w_state_nxt = S_SLOT0;
          w_cnt_nxt   = {CW{1'b0}};
          w_idx_nxt   = (r_idx == I_LAST) ? {IW{1'b0}} : r_idx + IW'(1);
        end else begin
          w_cnt_nxt   = r_cnt + CW'(1);
          w_state_nxt = (r_cnt + CW'(1) == C_BLANK) ? S_DRIVE : r_state;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = {CW{1'b0}};
        w_idx_nxt   = {IW{1'b0}};
      end
    endcase
  end

  assign w_commit   = (r_state != S_IDLE) && (r_idx == I_LAST) && (r_cnt == C_LAST) && r_pend_full;
  assign w_xfer     = bus.load_valid && !r_pend_full;
  assign w_disp_nxt = w_commit ? r_pend    : r_disp;
  assign w_dps_nxt  = w_commit ? r_pend_dp : r_dps;

  // Pending buffer and displayed set; a commit only happens from a full buffer, so it never races a transfer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_disp      <= {(4*DIGITS){1'b0}};
      r_dps       <= {DIGITS{1'b0}};
      r_pend      <= {(4*DIGITS){1'b0}};
      r_pend_dp   <= {DIGITS{1'b0}};
      r_pend_full <= 1'b0;
    end else if (w_commit) begin
      r_disp      <= r_pend;
      r_dps       <= r_pend_dp;
      r_pend_full <= 1'b0;
    end else if (w_xfer) begin
      r_pend      <= bus.load_data;
      r_pend_dp   <= bus.dp_in;
      r_pend_full <= 1'b1;
    end
  end

  // Digit select with suppression: walk from the MSD down, tracking whether everything above is zero.
  always_comb begin
    w_zero_run = 1'b1;
    w_hit      = 1'b0;
    w_nib      = 4'h0;
    w_sel_supp = 1'b0;
    w_sel_dp   = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_zero_run = w_zero_run & (w_disp_nxt[4*i +: 4] == 4'h0);
      w_hit      = (w_idx_nxt == IW'(i));
      w_nib      = w_hit ? w_disp_nxt[4*i +: 4] : w_nib;
      w_sel_supp = w_hit ? (bus.lz_en & w_zero_run & (i != 0)) : w_sel_supp;
      w_sel_dp   = w_hit ? w_dps_nxt[i] : w_sel_dp;
    end
    w_seg = w_sel_supp ? 7'h7F : seg_font(w_nib);
  end

  // Registered pin drive computed from the position being entered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ssg <= 7'h7F;
      r_dp  <= 1'b1;
      r_an  <= {DIGITS{1'b1}};
      r_ft  <= 1'b0;
    end else begin
      r_ft <= (w_cnt_nxt == {CW{1'b0}}) && (w_idx_nxt == {IW{1'b0}});
      if (w_state_nxt == S_DRIVE) begin
        r_an  <= ~(DIGITS'(1) << w_idx_nxt);
        r_ssg <= w_seg;
        r_dp  <= ~w_sel_dp;
      end else begin
        r_an  <= {DIGITS{1'b1}};
        r_ssg <= 7'h7F;
        r_dp  <= 1'b1;
      end
    end
  end

  assign bus.load_ready = ~r_pend_full;
  assign bus.ssg        = r_ssg;
  assign bus.dp         = r_dp;
  assign bus.an         = r_an;
  assign bus.frame_tick = r_ft;

endmodule

// File: tb/tb_ssg_scan_ctrl.sv
// Self-checking bench for ssg_scan_ctrl: directed plan steps, then random loads/resets against a cycle-count model.
module tb_ssg_scan_ctrl;

  localparam int D = 4;
  localparam int P = 8;
  localparam int B = 2;
  localparam logic [6:0] FONT [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                       7'b0100100, 7'b1100000, 7'b0001111, 7'b0000000, 7'b0001100};

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  ssg_scan_if #(.DIGITS(D)) bus ();

  ssg_scan_ctrl #(.DIGITS(D), .PRESCALE(P), .BLANK(B)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          m_k;
  bit          m_run;
  bit          m_full;
  logic [15:0] m_disp;
  logic [15:0] m_pend;
  logic [3:0]  m_dps;
  logic [3:0]  m_pdp;
  logic [6:0]  e_ssg;
  logic        e_dp;
  logic [3:0]  e_an;
  logic        e_ft;
  logic        e_rdy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model update at the active edge: commit at frame end, then handshake, then advance the cycle count.
  task automatic model_edge();
    bit rdy;
    int pos;
    int idx;
    int nib;
    bit supp;
    if (rst) begin
      m_run  = 1'b0;
      m_full = 1'b0;
      m_disp = 16'h0;
      m_dps  = 4'h0;
    end else begin
      rdy = !m_full;
      if (m_run && (m_k % (P*D)) == P*D - 1 && m_full) begin
        m_disp = m_pend;
        m_dps  = m_pdp;
        m_full = 1'b0;
      end
      if (bus.load_valid && rdy) begin
        m_pend = bus.load_data;
        m_pdp  = bus.dp_in;
        m_full = 1'b1;
      end
      if (m_run) m_k++;
      else begin
        m_run = 1'b1;
        m_k   = 0;
      end
    end
    e_rdy = !m_full;
    e_ssg = 7'h7F;
    e_dp  = 1'b1;
    e_an  = 4'hF;
    e_ft  = 1'b0;
    if (m_run) begin
      pos  = m_k % P;
      idx  = (m_k / P) % D;
      e_ft = ((m_k % (P*D)) == 0);
      if (pos >= B) begin
        e_an  = 4'hF ^ (4'b0001 << idx);
        nib   = (m_disp >> (4*idx)) & 15;
        supp  = bus.lz_en && idx > 0 && ((m_disp >> (4*idx)) == 0);
        e_ssg = (supp || nib > 9) ? 7'h7F : FONT[nib];
        e_dp  = !m_dps[idx];
      end
    end
  endtask

  // One clock: drive inputs, update the model on the edge, compare on the falling edge.
  task automatic cyc(input logic v, input logic [15:0] d, input logic [3:0] dpi, input logic lz, input logic r);
    bus.load_valid = v;
    bus.load_data  = d;
    bus.dp_in      = dpi;
    bus.lz_en      = lz;
    rst            = r;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("ssg", {25'd0, bus.ssg}, {25'd0, e_ssg});
    chk("dp", {31'd0, bus.dp}, {31'd0, e_dp});
    chk("an", {28'd0, bus.an}, {28'd0, e_an});
    chk("frame_tick", {31'd0, bus.frame_tick}, {31'd0, e_ft});
    chk("load_ready", {31'd0, bus.load_ready}, {31'd0, e_rdy});
  endtask

  task automatic go_to(input int target, input logic lz);
    int n;
    n = 0;
    while (m_k != target && n < 300) begin
      cyc(1'b0, 16'h0, 4'h0, lz, 1'b0);
      n++;
    end
    chk("goto_bound", m_k, target);
  endtask

  function automatic logic [15:0] rnd_data();
    logic [15:0] v;
    for (int i = 0; i < 4; i++) v[4*i +: 4] = ($urandom % 3 == 0) ? 4'h0 : 4'($urandom % 16);
    return v;
  endfunction

  initial begin
    logic        hv;
    logic [15:0] hd;
    logic [3:0]  hdp;
    logic        lz;
    logic        r;
    bit          acc;
    checks   = 0;
    failures = 0;
    m_k      = 0;
    m_run    = 1'b0;
    m_full   = 1'b0;
    m_disp   = 16'h0;
    m_pend   = 16'h0;
    m_dps    = 4'h0;
    m_pdp    = 4'h0;

    repeat (3) cyc(1'b0, 16'h0, 4'h0, 1'b0, 1'b1);
    chk("rst_ssg", {25'd0, bus.ssg}, 32'h7F);
    chk("rst_an", {28'd0, bus.an}, 32'hF);
    chk("rst_ready", {31'd0, bus.load_ready}, 32'h1);

    cyc(1'b0, 16'h0, 4'h0, 1'b0, 1'b0);
    chk("c0_tick", {31'd0, bus.frame_tick}, 32'h1);
    go_to(2, 1'b0);
    chk("c2_an", {28'd0, bus.an}, 32'hE);
    chk("c2_ssg", {25'd0, bus.ssg}, 32'b0000001);

    go_to(3, 1'b0);
    cyc(1'b1, 16'h1234, 4'b0100, 1'b0, 1'b0);
    chk("c4_ready_low", {31'd0, bus.load_ready}, 32'h0);
    go_to(32, 1'b0);
    chk("c32_ready", {31'd0, bus.load_ready}, 32'h1);
    go_to(34, 1'b0);
    chk("c34_an", {28'd0, bus.an}, 32'hE);
    chk("c34_ssg", {25'd0, bus.ssg}, 32'b1001100);
    go_to(50, 1'b0);
    chk("c50_an", {28'd0, bus.an}, 32'hB);
    chk("c50_ssg", {25'd0, bus.ssg}, 32'b0010010);
    chk("c50_dp", {31'd0, bus.dp}, 32'h0);

    cyc(1'b1, 16'hA0F9, 4'h0, 1'b0, 1'b0);
    go_to(66, 1'b0);
    chk("inv_d0", {21'd0, bus.an, bus.ssg}, {21'd0, 4'hE, 7'b0001100});
    go_to(74, 1'b0);
    chk("inv_d1", {21'd0, bus.an, bus.ssg}, {21'd0, 4'hD, 7'h7F});
    go_to(82, 1'b0);
    chk("inv_d2", {21'd0, bus.an, bus.ssg}, {21'd0, 4'hB, 7'b0000001});
    go_to(90, 1'b0);
    chk("inv_d3", {21'd0, bus.an, bus.ssg}, {21'd0, 4'h7, 7'h7F});

    cyc(1'b1, 16'h0050, 4'h0, 1'b1, 1'b0);
    go_to(130, 1'b1);
    chk("lz_d0", {21'd0, bus.an, bus.ssg}, {21'd0, 4'hE, 7'b0000001});
    go_to(138, 1'b1);
    chk("lz_d1", {21'd0, bus.an, bus.ssg}, {21'd0, 4'hD, 7'b0100100});
    go_to(146, 1'b1);
    chk("lz_d2", {21'd0, bus.an, bus.ssg}, {21'd0, 4'hB, 7'h7F});
    go_to(154, 1'b1);
    chk("lz_d3", {21'd0, bus.an, bus.ssg}, {21'd0, 4'h7, 7'h7F});

    go_to(158, 1'b1);
    cyc(1'b1, 16'h1111, 4'h3, 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 4'h0, 1'b0, 1'b1);
    chk("midrst_ready", {31'd0, bus.load_ready}, 32'h1);
    chk("midrst_an", {28'd0, bus.an}, 32'hF);
    cyc(1'b0, 16'h0, 4'h0, 1'b0, 1'b0);
    go_to(26, 1'b0);
    chk("midrst_d3", {21'd0, bus.an, bus.ssg}, {21'd0, 4'h7, 7'b0000001});

    hv  = 1'b0;
    hd  = 16'h0;
    hdp = 4'h0;
    lz  = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (!hv && ($urandom % 5 == 0)) begin
        hv  = 1'b1;
        hd  = rnd_data();
        hdp = 4'($urandom % 16);
      end
      if ($urandom % 40 == 0) lz = !lz;
      r   = ($urandom % 400 == 0);
      acc = hv && !m_full && !r;
      cyc(hv, hd, hdp, lz, r);
      if (acc) hv = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
